switch_debouncer: RTL
=====================

// Module: switch_debouncer
// PURPOSE
//   Conditions the raw mechanical switch input before it reaches the LED pattern controller.
//   Synchronises the asynchronous input and filters bounce with a stability counter.
//   Produces a clean level plus one-cycle rise/fall/long-press strobes.
//   Its 'switch' output drives the LED controller's 'switch' input directly.
// PARAMETERS
//   SYNC_STAGES        2   flip-flop depth of the input synchroniser (>=2)
//   DEBOUNCE_CYCLES    4   consecutive stable samples required to accept a new level (>=1)
//   LONG_PRESS_CYCLES  16  cycles of accepted high level before long_press fires (>DEBOUNCE_CYCLES)
//   CNT_W              $clog2(LONG_PRESS_CYCLES+1)  shared counter width, derived, not overridden
// PORTS
//   clk         in   1  system clock, rising edge
//   rst         in   1  reset; one clock, reset is asynchronous and active-low
//   enable      in   1  sample enable; 0 freezes the counter and state, all strobes forced 0
//   switch_raw  in   1  raw asynchronous switch pin
//   switch      out  1  debounced level, feeds LED controller 'switch'
//   rise        out  1  one-cycle strobe on accepted 0->1
//   fall        out  1  one-cycle strobe on accepted 1->0
//   long_press  out  1  one-cycle strobe after LONG_PRESS_CYCLES of continuous accepted high
// BEHAVIOUR
//   - Reset (rst=0, async): sync chain, counter cleared to 0; state=IDLE_LO; all outputs 0.
//   - Synchroniser: switch_raw passes SYNC_STAGES flops; 's' = last stage. Always clocks, ignores enable.
//   - FSM states: IDLE_LO, CHK_HI, HELD_HI, LONG_HI, CHK_LO. switch=1 in HELD_HI, LONG_HI, CHK_LO.
//   - IDLE_LO: s=1 -> CHK_HI, cnt=1.
//   - CHK_HI: s=0 -> IDLE_LO, cnt=0 (bounce rejected, no strobe);
//     s=1 & cnt==DEBOUNCE_CYCLES-1 -> HELD_HI, rise=1, cnt=0; else cnt++.
//   - HELD_HI: s=0 -> CHK_LO, cnt=1;
//     s=1 & cnt==LONG_PRESS_CYCLES-1 -> LONG_HI, long_press=1; else cnt++.
//   - LONG_HI: s=0 -> CHK_LO, cnt=1; long_press fires once per press, never repeats.
//   - CHK_LO: s=1 -> HELD_HI, cnt=0 (long-press timing restarts);
//     s=0 & cnt==DEBOUNCE_CYCLES-1 -> IDLE_LO, fall=1, cnt=0; else cnt++.
//   - DEBOUNCE_CYCLES=1: CHK_* accepts on the first stable sample, one cycle after entry.
//   - Latency: switch_raw step to switch/rise = SYNC_STAGES + DEBOUNCE_CYCLES cycles.
//   - All outputs registered; strobes high exactly one cycle; rise/fall/long_press mutually exclusive.
//   - enable=0: state, cnt and switch hold; strobes 0. A transition due that cycle completes on the
//     first enabled cycle. No strobe is lost or duplicated.
//   - Counter saturates at LONG_PRESS_CYCLES-1; no wrap-around.
//   - Reset mid-check or mid-press: immediate return to IDLE_LO, no fall strobe emitted.
//   - Input already high when reset releases: debounced normally, then a rise strobe is emitted.
// STRUCTURE
//   - Package debounce_pkg: typedef enum logic [2:0] deb_state_t {IDLE_LO, CHK_HI, HELD_HI,
//     LONG_HI, CHK_LO}.
//   - Sub-module sync_ff #(STAGES,W): generic async-low-reset synchroniser chain, reusable elsewhere.
//   - Top level: one always_ff for state/cnt/outputs, one always_comb for next-state.
// TESTING
//   - Reset release with switch_raw=0, 10 cycles -> switch, rise, fall, long_press all stay 0.
//   - Clean step 0->1 at cycle 0, held 30 cycles (defaults) -> rise at cycle 6; switch=1 from
//     cycle 6; long_press once at cycle 22.
//   - Bounce 1,0,1,0 one cycle each, then stable 1 -> single rise, 6 cycles after the stable edge;
//     no fall.
//   - Release pulse: switch=1, raw=0 for 2 cycles then back to 1 -> switch stays 1, no fall;
//     long_press count restarts.
//   - enable=0 while in CHK_HI, held 5 cycles -> no rise during hold;
//     rise arrives after enable=1 with the same remaining count.
//   - rst=0 asserted mid-press in LONG_HI -> outputs 0 immediately, asynchronously; no fall strobe.
//   - Scoreboard checks one-cycle strobe width and mutual exclusion of rise/fall/long_press.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types for the switch debouncer: FSM state encoding and a level-decode helper.
package debounce_pkg;

    typedef enum logic [2:0] {
        IDLE_LO = 3'd0,
        CHK_HI  = 3'd1,
        HELD_HI = 3'd2,
        LONG_HI = 3'd3,
        CHK_LO  = 3'd4
    } deb_state_t;

    // Debounced level implied by a state; CHK_LO still reports high until release is accepted.
    function automatic logic level_of(input deb_state_t st);
        logic lvl;
        lvl = 1'b0;
        case (st)
            HELD_HI, LONG_HI, CHK_LO: lvl = 1'b1;
            default:                  lvl = 1'b0;
        endcase
        return lvl;
    endfunction

endpackage : debounce_pkg

// File: rtl/sync_ff.sv
// Generic multi-stage synchroniser chain with asynchronous active-low reset.
module sync_ff #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned W      = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [STAGES-1:0][W-1:0] chain_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule : sync_ff

// File: rtl/switch_debouncer.sv
// Switch conditioner: synchronise the raw pin, filter bounce, emit a clean level
// plus registered rise/fall/long-press strobes.
module switch_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned DEBOUNCE_CYCLES   = 4,
    parameter int unsigned LONG_PRESS_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic switch_raw,
    output logic switch,
    output logic rise,
    output logic fall,
    output logic long_press
);

    localparam int unsigned CNT_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

    logic             s;
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             switch_q, switch_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             long_q, long_d;

    sync_ff #(
        .STAGES (SYNC_STAGES),
        .W      (1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (switch_raw),
        .q_o   (s)
    );

    // State, shared counter and all outputs are registered together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE_LO;
            cnt_q    <= CNT_ZERO;
            switch_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            long_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            switch_q <= switch_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            long_q   <= long_d;
        end
    end

    // Next-state logic; a disabled cycle leaves everything as-is so a due transition
    // is simply re-evaluated on the next enabled cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        long_d  = 1'b0;

        if (enable) begin
            case (state_q)
                IDLE_LO: begin
                    if (s) begin
                        state_d = CHK_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
                CHK_HI: begin
                    if (!s) begin
                        state_d = IDLE_LO;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q >= DEB_LAST) begin
                        state_d = HELD_HI;
                        cnt_d   = CNT_ZERO;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                HELD_HI: begin
                    if (!s) begin
                        state_d = CHK_LO;
                        cnt_d   = CNT_ONE;
                    end else if (cnt_q >= LONG_LAST) begin
                        state_d = LONG_HI;
                        long_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                LONG_HI: begin
                    // Counter parks at its saturation value; long_press cannot repeat here.
                    if (!s) begin
                        state_d = CHK_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
                CHK_LO: begin
                    if (s) begin
                        state_d = HELD_HI;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q >= DEB_LAST) begin
                        state_d = IDLE_LO;
                        cnt_d   = CNT_ZERO;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE_LO;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end

        switch_d = level_of(state_d);
    end

    assign switch     = switch_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign long_press = long_q;

endmodule : switch_debouncer
